// File: rtl/tlk2711_pkg.sv
// Shared types and helpers for the TLK2711 RX write-DMA arbiter.
// Holds the arbiter state encoding, the default beat size and the byte-to-beat conversion.
package tlk2711_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD      = 2'd1,
    ST_DATA     = 2'd2,
    ST_WAIT_FIN = 2'd3
  } arb_state_e;

  localparam int BEAT_BYTES = 8;

  // Partial trailing beats count as a whole beat.
  function automatic logic [31:0] beat_count(input logic [31:0] byte_len,
                                             input logic [31:0] beat_bytes);
    return (byte_len / beat_bytes) + {31'd0, ((byte_len % beat_bytes) != 32'd0)};
  endfunction

endpackage

// File: rtl/tlk2711_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
// found is low when no request is pending.
module tlk2711_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [PW-1:0]      grant,
  output logic               found
);

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        grant = PW'((int'(rr_ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlk2711_wr_dma_arbiter.sv
// Frame-granular round-robin sharing of one DDR write-DMA engine between NUM_REQ RX link channels.
// Optional idle abort enabled by defining TLK2711_ARB_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | no grant active, picking next requester
// ST_CMD      | command presented to DMA, waiting for ack
// ST_DATA     | streaming granted channel's beats to DMA
// ST_WAIT_FIN | all beats sent, waiting for DMA write finish
module tlk2711_wr_dma_arbiter
  import tlk2711_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DLEN_WIDTH  = 16,
  parameter int DATA_WIDTH  = BEAT_BYTES * 8,
  parameter int TIMEOUT_CYC = 10000000
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            i_req_cmd_req,
  input  logic [NUM_REQ*(ADDR_WIDTH+DLEN_WIDTH)-1:0]    i_req_cmd_data,
  output logic [NUM_REQ-1:0]                            o_req_cmd_ack,
  input  logic [NUM_REQ-1:0]                            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                 i_req_data,
  output logic [NUM_REQ-1:0]                            o_req_ready,
  output logic [NUM_REQ-1:0]                            o_req_finish,
  output logic                                          o_wr_cmd_req,
  input  logic                                          i_wr_cmd_ack,
  output logic [ADDR_WIDTH+DLEN_WIDTH-1:0]              o_wr_cmd_data,
  output logic                                          o_dma_wr_valid,
  output logic [DATA_WIDTH-1:0]                         o_dma_wr_data,
  output logic [DATA_WIDTH/8-1:0]                       o_dma_wr_keep,
  input  logic                                          i_dma_wr_ready,
  input  logic                                          i_wr_finish,
  output logic [$clog2(NUM_REQ)-1:0]                    o_grant_id,
  output logic                                          o_busy,
  output logic                                          o_timeout
);

  localparam int          CW     = ADDR_WIDTH + DLEN_WIDTH;
  localparam int          PW     = $clog2(NUM_REQ);
  localparam logic [31:0] BEAT_B = 32'(DATA_WIDTH / 8);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("tlk2711_wr_dma_arbiter: parameter out of range");
  end

  arb_state_e            state, state_nxt;
  logic [PW-1:0]         rr_ptr, grant, pick_id, grant_inc;
  logic                  pick_found;
  logic [CW-1:0]         cmd_data, sel_cmd;
  logic [DLEN_WIDTH-1:0] sel_len, beats_left;
  logic                  fin_pend, beat, fin_evt, tmo_hit;

  tlk2711_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (i_req_cmd_req),
    .rr_ptr (rr_ptr),
    .grant  (pick_id),
    .found  (pick_found)
  );

  assign sel_cmd   = i_req_cmd_data[int'(pick_id)*CW +: CW];
  assign sel_len   = sel_cmd[DLEN_WIDTH-1:0];
  assign beat      = (state == ST_DATA) && i_req_valid[grant] && i_dma_wr_ready;
  assign fin_evt   = (state == ST_WAIT_FIN) && (i_wr_finish || fin_pend);
  assign grant_inc = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

`ifdef TLK2711_ARB_TIMEOUT_EN
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_cnt;
  logic        tmo_clr;

  assign tmo_clr = (state == ST_IDLE) || ((state == ST_CMD) && i_wr_cmd_ack) || beat || fin_evt;
  assign tmo_hit = !tmo_clr && (tmo_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || tmo_clr || tmo_hit) tmo_cnt <= TMO_LOAD;
    else                           tmo_cnt <= tmo_cnt - 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (pick_found) state_nxt = ST_CMD;
      ST_CMD:      if (i_wr_cmd_ack) state_nxt = (beats_left == '0) ? ST_WAIT_FIN : ST_DATA;
      ST_DATA:     if (beat && (beats_left == DLEN_WIDTH'(1))) state_nxt = ST_WAIT_FIN;
      ST_WAIT_FIN: if (fin_evt) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (tmo_hit) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant      <= '0;
      cmd_data   <= '0;
      beats_left <= '0;
      fin_pend   <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && pick_found) begin
        grant      <= pick_id;
        cmd_data   <= sel_cmd;
        beats_left <= DLEN_WIDTH'(beat_count(32'(sel_len), BEAT_B));
      end
      if (beat) beats_left <= beats_left - 1'b1;
      if (fin_evt || tmo_hit) rr_ptr <= grant_inc;
      // An early finish (e.g. with the last beat) is held until WAIT_FIN consumes it.
      if (tmo_hit || (state == ST_WAIT_FIN)) fin_pend <= 1'b0;
      else if (i_wr_finish)                  fin_pend <= 1'b1;
    end
  end

  always_comb begin
    o_req_cmd_ack  = '0;
    o_req_ready    = '0;
    o_req_finish   = '0;
    o_dma_wr_valid = 1'b0;
    o_dma_wr_data  = '0;
    case (state)
      ST_CMD:  o_req_cmd_ack[grant] = i_wr_cmd_ack;
      ST_DATA: begin
        o_dma_wr_valid     = i_req_valid[grant];
        o_req_ready[grant] = i_dma_wr_ready;
        o_dma_wr_data      = i_req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      end
      ST_WAIT_FIN: o_req_finish[grant] = i_wr_finish || fin_pend;
      default: ;
    endcase
  end

  assign o_wr_cmd_req  = (state == ST_CMD);
  assign o_wr_cmd_data = cmd_data;
  assign o_dma_wr_keep = '1;
  assign o_grant_id    = grant;
  assign o_busy        = (state != ST_IDLE);
  assign o_timeout     = tmo_hit;

endmodule

// File: tb/tb_tlk2711_wr_dma_arbiter.sv
// Directed + randomized bench for tlk2711_wr_dma_arbiter, acting as rx channels and DMA engine.
// Grant order comes from a round-robin model over the request mask; TLK2711_ARB_TIMEOUT_EN selects the abort checks.
module tb_tlk2711_wr_dma_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 64;
  localparam int CW = AW + LW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     i_req_cmd_req = '0;
  logic [NR*CW-1:0]  i_req_cmd_data = '0;
  logic [NR-1:0]     o_req_cmd_ack;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR*DW-1:0]  i_req_data = '0;
  logic [NR-1:0]     o_req_ready;
  logic [NR-1:0]     o_req_finish;
  logic              o_wr_cmd_req;
  logic              i_wr_cmd_ack = 1'b0;
  logic [CW-1:0]     o_wr_cmd_data;
  logic              o_dma_wr_valid;
  logic [DW-1:0]     o_dma_wr_data;
  logic [DW/8-1:0]   o_dma_wr_keep;
  logic              i_dma_wr_ready = 1'b0;
  logic              i_wr_finish = 1'b0;
  logic [1:0]        o_grant_id;
  logic              o_busy;
  logic              o_timeout;

  int            checks = 0;
  int            failures = 0;
  int            rr_model = 0;
  logic [NR-1:0] req_mask = '0;
  logic [CW-1:0] cmd [NR];

  always #5 clk = ~clk;

  tlk2711_wr_dma_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DLEN_WIDTH(LW), .DATA_WIDTH(DW), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_cmd_req(i_req_cmd_req), .i_req_cmd_data(i_req_cmd_data), .o_req_cmd_ack(o_req_cmd_ack),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_req_finish(o_req_finish), .o_wr_cmd_req(o_wr_cmd_req), .i_wr_cmd_ack(i_wr_cmd_ack),
    .o_wr_cmd_data(o_wr_cmd_data), .o_dma_wr_valid(o_dma_wr_valid), .o_dma_wr_data(o_dma_wr_data),
    .o_dma_wr_keep(o_dma_wr_keep), .i_dma_wr_ready(i_dma_wr_ready), .i_wr_finish(i_wr_finish),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int ch);
    logic [NR-1:0] one;
    one = 1;
    return one << ch;
  endfunction

  // Round-robin rule: nearest requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NR-1:0] m, input int rr);
    for (int i = 0; i < NR; i++) if (m[(rr + i) % NR]) return (rr + i) % NR;
    return 0;
  endfunction

  task automatic drive_idle();
    i_req_valid = '0;
    i_dma_wr_ready = 1'b0;
    i_wr_cmd_ack = 1'b0;
    i_wr_finish = 1'b0;
  endtask

  task automatic set_req(input int k, input int len);
    cmd[k] = {$urandom(), 16'(len)};
    i_req_cmd_data[k*CW +: CW] = cmd[k];
    req_mask[k] = 1'b1;
    i_req_cmd_req = req_mask;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    req_mask = '0;
    i_req_cmd_req = '0;
    i_req_cmd_data = '0;
    @(negedge clk); #1;
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_cmd_req", 64'(o_wr_cmd_req), 64'(0));
    check("rst_cmd_ack", 64'(o_req_cmd_ack), 64'(0));
    check("rst_ready", 64'(o_req_ready), 64'(0));
    check("rst_finish", 64'(o_req_finish), 64'(0));
    check("rst_dma_valid", 64'(o_dma_wr_valid), 64'(0));
    check("rst_dma_data", o_dma_wr_data, 64'(0));
    check("rst_keep", 64'(o_dma_wr_keep), 64'(8'hFF));
    check("rst_grant", 64'(o_grant_id), 64'(0));
    check("rst_cmd_data", 64'(o_wr_cmd_data), 64'(0));
    check("rst_timeout", 64'(o_timeout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    rr_model = 0;
  endtask

  task automatic start_frame(input int ch, input bit rearm);
    int n;
    n = 0;
    @(negedge clk); drive_idle(); #1;
    while (!o_wr_cmd_req && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check("cmd_req_wait", 64'(o_wr_cmd_req), 64'(1));
    check("grant_id", 64'(o_grant_id), 64'(ch));
    check("wr_cmd_data", 64'(o_wr_cmd_data), 64'(cmd[ch]));
    check("busy_cmd", 64'(o_busy), 64'(1));
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1;
      check("cmd_req_hold", 64'(o_wr_cmd_req), 64'(1));
      check("cmd_ack_early", 64'(o_req_cmd_ack), 64'(0));
    end
    @(negedge clk);
    i_wr_cmd_ack = 1'b1;
    #1;
    check("cmd_ack", 64'(o_req_cmd_ack), 64'(oh(ch)));
    if (rearm) set_req(ch, $urandom_range(0, 160));
    else begin
      req_mask[ch] = 1'b0;
      i_req_cmd_req = req_mask;
    end
  endtask

  task automatic send_beats(input int ch, input int n, input int rpct, input int vpct, input bit fin_last);
    int got, cyc;
    bit v, r;
    logic [DW-1:0] exp_d;
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 40 + 50) begin
      @(negedge clk);
      drive_idle();
      v = ($urandom_range(1, 100) <= vpct);
      r = ($urandom_range(1, 100) <= rpct);
      for (int k = 0; k < NR; k++) i_req_data[k*DW +: DW] = {$urandom(), $urandom()};
      i_req_valid = NR'($urandom());
      i_req_valid[ch] = v;
      i_dma_wr_ready = r;
      if (v && r && got == n - 1 && fin_last) i_wr_finish = 1'b1;
      exp_d = i_req_data[ch*DW +: DW];
      #1;
      check("dma_valid", 64'(o_dma_wr_valid), 64'(v));
      check("req_ready", 64'(o_req_ready), 64'(r ? oh(ch) : '0));
      if (v) check("dma_data", o_dma_wr_data, exp_d);
      if (v && r) got++;
      cyc++;
    end
    check("beats_in_budget", 64'(got == n), 64'(1));
  endtask

  task automatic end_frame(input int ch, input bit fin_done);
    @(negedge clk);
    drive_idle();
    i_req_valid = oh(ch);
    i_dma_wr_ready = 1'b1;
    if (!fin_done) begin
      #1;
      check("no_extra_beat", 64'(o_dma_wr_valid), 64'(0));
      check("finish_early", 64'(o_req_finish), 64'(0));
      check("busy_wait_fin", 64'(o_busy), 64'(1));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); #1;
        check("finish_early", 64'(o_req_finish), 64'(0));
      end
      @(negedge clk);
      i_wr_finish = 1'b1;
    end
    #1;
    check("dma_valid_after_last", 64'(o_dma_wr_valid), 64'(0));
    check("req_finish", 64'(o_req_finish), 64'(oh(ch)));
    rr_model = (ch + 1) % NR;
    @(negedge clk); drive_idle(); #1;
    check("idle_after_fin", 64'(o_busy), 64'(0));
    check("finish_once", 64'(o_req_finish), 64'(0));
    check("no_grant_in_fin_cycle", 64'(o_wr_cmd_req), 64'(0));
  endtask

  task automatic run_frame(input int ch, input int rpct, input int vpct, input bit fin_last, input bit rearm);
    int len, nb;
    len = int'(cmd[ch][LW-1:0]);
    nb = (len + 7) / 8;
    start_frame(ch, rearm);
    if (nb > 0) send_beats(ch, nb, rpct, vpct, fin_last);
    end_frame(ch, fin_last && nb > 0);
  endtask

  initial begin
    int ch, a, b;
    int order[5] = '{0, 1, 2, 3, 0};

    reset_dut();

    // Single requester on channel 1, 882 bytes -> 111 beats.
    set_req(1, 882);
    run_frame(1, 100, 70, 1'b0, 1'b0);

    // All four held from rr_ptr 0.
    reset_dut();
    for (int k = 0; k < NR; k++) set_req(k, $urandom_range(0, 160));
    for (int i = 0; i < 5; i++) run_frame(order[i], 80, 80, 1'b0, i < 4);

    // 10752-byte frame with DMA ready toggling about half the time.
    reset_dut();
    ch = $urandom_range(0, NR - 1);
    set_req(ch, 10752);
    run_frame(model_pick(req_mask, rr_model), 50, 100, 1'b0, 1'b0);

    // Zero-length command.
    ch = $urandom_range(0, NR - 1);
    set_req(ch, 0);
    run_frame(model_pick(req_mask, rr_model), 100, 100, 1'b0, 1'b0);

    // Finish coincident with last beat, with another channel waiting.
    a = $urandom_range(0, NR - 1);
    b = (a + $urandom_range(1, NR - 1)) % NR;
    set_req(a, $urandom_range(1, 200));
    set_req(b, $urandom_range(1, 200));
    run_frame(model_pick(req_mask, rr_model), 100, 100, 1'b1, 1'b0);
    run_frame(model_pick(req_mask, rr_model), 60, 60, 1'b1, 1'b0);

    // Randomized request mixes.
    repeat (6) begin
      for (int k = 0; k < NR; k++)
        if (!req_mask[k] && $urandom_range(0, 1) == 1) set_req(k, $urandom_range(0, 300));
      if (req_mask == '0) set_req($urandom_range(0, NR - 1), $urandom_range(1, 300));
      run_frame(model_pick(req_mask, rr_model), $urandom_range(30, 100), $urandom_range(30, 100),
                1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a data phase.
    reset_dut();
    ch = $urandom_range(0, NR - 1);
    set_req(ch, 800);
    start_frame(ch, 1'b0);
    send_beats(ch, 3, 100, 100, 1'b0);
    reset_dut();

    // Valid stuck low mid-frame.
    ch = $urandom_range(0, NR - 1);
    set_req(ch, 64);
    start_frame(ch, 1'b0);
    send_beats(ch, 3, 100, 100, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      drive_idle();
      i_dma_wr_ready = 1'b1;
      #1;
`ifdef TLK2711_ARB_TIMEOUT_EN
      check("timeout_pulse", 64'(o_timeout), 64'(i == 100));
`else
      check("timeout_off", 64'(o_timeout), 64'(0));
`endif
      check("stall_no_finish", 64'(o_req_finish), 64'(0));
    end
    @(negedge clk); drive_idle(); #1;
`ifdef TLK2711_ARB_TIMEOUT_EN
    check("idle_after_timeout", 64'(o_busy), 64'(0));
    check("timeout_once", 64'(o_timeout), 64'(0));
    rr_model = (ch + 1) % NR;
    for (int k = 0; k < NR; k++) set_req(k, $urandom_range(0, 100));
    run_frame(model_pick(req_mask, rr_model), 100, 100, 1'b0, 1'b0);
`else
    check("stall_still_busy", 64'(o_busy), 64'(1));
    send_beats(ch, 5, 100, 100, 1'b0);
    end_frame(ch, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
